// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
package adder_seq_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAdd  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned NIB_W = 4;

   function automatic int unsigned num_steps(input int unsigned opw);
      return opw / NIB_W;
   endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-carry adder built from full-adder cells.
module nibble_add_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[4];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Adds two OPW-bit operands one nibble per cycle through a single 4-bit slice.
// Optional subtract mode (io_in_sub port) is enabled by defining ADDER_SEQ_SUB_EN.
module adder_seq_ctrl
   import adder_seq_pkg::*;
#(
   parameter int unsigned OPW = 16
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           io_in_valid,
   output logic           io_in_ready,
   input  logic [OPW-1:0] io_in_x,
   input  logic [OPW-1:0] io_in_y,
   input  logic           io_in_cin,
`ifdef ADDER_SEQ_SUB_EN
   input  logic           io_in_sub,
`endif
   output logic           io_out_valid,
   input  logic           io_out_ready,
   output logic [OPW-1:0] io_out_sum,
   output logic           io_out_cout,
   output logic           io_busy
);

   localparam int unsigned NumSteps = num_steps(OPW);
   localparam int unsigned StepW    = (NumSteps > 1) ? $clog2(NumSteps) : 1;
   localparam logic [StepW-1:0] LastStep = StepW'(NumSteps - 1);

   if ((OPW % NIB_W) != 0 || OPW < NIB_W) begin : g_bad_opw
      $error("adder_seq_ctrl: OPW must be a multiple of 4 and >= 4");
   end

   state_e           state_q, state_d;
   logic [StepW-1:0] step_q, step_d;
   logic [OPW-1:0]   x_q, x_d;
   logic [OPW-1:0]   y_q, y_d;
   logic [OPW-1:0]   sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;

   logic [NIB_W-1:0] nib_x, nib_y, nib_s;
   logic             nib_cout;

   // Select the operand nibbles addressed by the step counter.
   always_comb begin
      nib_x = '0;
      nib_y = '0;
      for (int unsigned i = 0; i < NumSteps; i++) begin
         if (step_q == StepW'(i)) begin
            nib_x = x_q[i*NIB_W +: NIB_W];
            nib_y = y_q[i*NIB_W +: NIB_W];
         end
      end
   end

   nibble_add_slice u_slice (
      .a    (nib_x),
      .b    (nib_y),
      .cin  (carry_q),
      .s    (nib_s),
      .cout (nib_cout)
   );

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      x_d     = x_q;
      y_d     = y_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;

      case (state_q)
         StIdle: begin
            if (io_in_valid) begin
               x_d = io_in_x;
`ifdef ADDER_SEQ_SUB_EN
               // Subtract as x + ~y + 1; the forced carry-in replaces cin.
               y_d     = io_in_sub ? ~io_in_y : io_in_y;
               carry_d = io_in_sub ? 1'b1 : io_in_cin;
`else
               y_d     = io_in_y;
               carry_d = io_in_cin;
`endif
               step_d  = '0;
               state_d = StAdd;
            end
         end
         StAdd: begin
            for (int unsigned i = 0; i < NumSteps; i++) begin
               if (step_q == StepW'(i)) begin
                  sum_d[i*NIB_W +: NIB_W] = nib_s;
               end
            end
            carry_d = nib_cout;
            if (step_q == LastStep) begin
               cout_d  = nib_cout;
               state_d = StDone;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         StDone: begin
            if (io_out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         step_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign io_in_ready  = (state_q == StIdle);
   assign io_out_valid = (state_q == StDone);
   assign io_busy      = (state_q == StAdd) || (state_q == StDone);
   assign io_out_sum   = sum_q;
   assign io_out_cout  = cout_q;

endmodule
